// File: rtl/message_writer.sv
// message_writer: composes a short message from switch codes and two
// pushbuttons (write / clear). Each button is synchronised, debounced and
// turned into a single-cycle press event. The character buffer is read
// combinationally by the display side.
module message_writer #(
    parameter int                DEPTH    = 8,
    parameter int                CODE_W   = 3,
    parameter logic [CODE_W-1:0] BLANK    = 3'b100,
    parameter int                DEBOUNCE = 500000
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [CODE_W-1:0]          char_in,
    input  logic                       wr_btn,
    input  logic                       clr_btn,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [CODE_W-1:0]          rd_data,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       wr_ack
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DEB_ONE  = CW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Button index 0 = write, 1 = clear; both share the same pipeline so
    // simultaneous presses yield coincident events.
    logic [1:0] btn_raw;
    logic [1:0] press_event;

    assign btn_raw = {clr_btn, wr_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          prev_reg;
            logic          level_reg;
            logic          level_next;
            logic          press_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            // Stability counter: restart on any change, saturate once stable.
            always_comb begin
                cnt_next   = cnt_reg;
                level_next = level_reg;
                if (sync2_reg != prev_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg != DEB_MAX) begin
                    cnt_next = cnt_reg + DEB_ONE;
                end
                if (cnt_next == DEB_MAX) begin
                    level_next = sync2_reg;
                end
            end

            // Synchroniser, debounce state and press-edge detection.
            always_ff @(posedge CLOCK_50) begin
                if (!resetn) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    prev_reg  <= 1'b1;
                    level_reg <= 1'b1;
                    cnt_reg   <= '0;
                    press_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    press_reg <= level_reg & ~level_next;
                end
            end

            assign press_event[gi] = press_reg;
        end
    endgenerate

    logic                wr_event;
    logic                clr_event;
    logic [AW-1:0]       ptr_reg;
    logic [AW-1:0]       ptr_next;
    logic [AW:0]         count_reg;
    logic [AW:0]         count_next;
    logic                ack_reg;
    logic                ack_next;
    logic                do_write;
    logic                do_clear;
    logic [DEPTH-1:0]    slot_we;
    logic [CODE_W-1:0]   buf_reg [DEPTH];

    assign wr_event  = press_event[0];
    assign clr_event = press_event[1];
    assign full      = (count_reg == CNT_FULL);

    // Event arbitration: clear beats write; writes into a full buffer are dropped.
    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        ack_next   = 1'b0;
        do_write   = 1'b0;
        do_clear   = 1'b0;
        if (clr_event) begin
            ptr_next   = '0;
            count_next = '0;
            do_clear   = 1'b1;
        end else if (wr_event && !full) begin
            ptr_next   = ptr_reg + PTR_ONE;
            count_next = count_reg + CNT_ONE;
            ack_next   = 1'b1;
            do_write   = 1'b1;
        end
    end

    // Pointer, fill count and acknowledge pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            ack_reg   <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            ack_reg   <= ack_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign slot_we[gi] = do_write && (ptr_reg == AW'(gi));
        end
    endgenerate

    // Character buffer: blanked on reset or clear, one slot written per event.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn || do_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_reg[i] <= BLANK;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    buf_reg[i] <= char_in;
                end
            end
        end
    end

    assign rd_data = buf_reg[rd_addr];
    assign wr_ptr  = ptr_reg;
    assign count   = count_reg;
    assign wr_ack  = ack_reg;

endmodule
